// File: rtl/ecc_scalar_mul_bus_frontend.sv
// Bus frontend for the ECC scalar-multiplier core: holds operands, runs the start/done handshake, and captures results, status and the cycle count.
// Latency: a start write launches core_start the next cycle; core_done gives done and readable results the next cycle; reads return one cycle after rd_en.
// Backpressure: the bus never stalls; operand, ctrl and start writes while busy are dropped and set err, and clr is always honoured.
module ecc_scalar_mul_bus_frontend #(
    parameter int BUS_W       = 32,
    parameter int OP_W        = 256,
    parameter int ADDR_W      = 5,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BUS_W-1:0]  wr_data,
    output logic [BUS_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              irq,
    output logic              core_start,
    output logic [OP_W-1:0]   core_k,
    output logic [OP_W-1:0]   core_px,
    output logic [OP_W-1:0]   core_py,
    output logic              core_pinf,
    input  logic              core_done,
    input  logic [OP_W-1:0]   core_x,
    input  logic [OP_W-1:0]   core_y,
    input  logic              core_inf
);

    localparam int W = OP_W / BUS_W;

    // Write-side and read-side register addresses.
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(3 * W);
    localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(3 * W + 1);
    localparam logic [ADDR_W-1:0] A_INF  = ADDR_W'(2 * W);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(2 * W + 1);
    localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'(2 * W + 2);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  x_res, y_res;
    logic             inf_res;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             err, timeout, done_sticky;
    logic             busy, op_wr, cmd_wr, start_wr, clr_wr, wait_done, wait_tmo;
    logic [BUS_W-1:0] rd_mux;

    assign busy      = (state_q != S_IDLE);
    assign cmd_wr    = wr_en && (addr == A_CMD);
    assign start_wr  = cmd_wr && wr_data[0];
    assign clr_wr    = cmd_wr && wr_data[1];
    // Operand words and ctrl occupy every address below cmd.
    assign op_wr     = wr_en && (addr < A_CMD);
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign wait_done = (state_q == S_WAIT) && core_done;
    // A core answer in the same cycle as the timeout wins, so the result is kept.
    assign wait_tmo  = (state_q == S_WAIT) && !core_done && (TIMEOUT_CYC != 0)
                       && (cnt_inc == CNT_W'(TIMEOUT_CYC));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode; core_start and done are single-cycle states.
    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE:   if (start_wr) state_d = S_LAUNCH;
            S_LAUNCH: begin
                core_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT:   if (wait_done || wait_tmo) state_d = S_FIN;
            S_FIN:    begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Operand and ctrl registers; frozen while an operation is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_k    <= '0;
            core_px   <= '0;
            core_py   <= '0;
            core_pinf <= 1'b0;
        end else if (wr_en && !busy) begin
            for (int i = 0; i < W; i++) begin
                if (addr == ADDR_W'(i))         core_k[i*BUS_W +: BUS_W]  <= wr_data;
                if (addr == ADDR_W'(W + i))     core_px[i*BUS_W +: BUS_W] <= wr_data;
                if (addr == ADDR_W'(2 * W + i)) core_py[i*BUS_W +: BUS_W] <= wr_data;
            end
            if (addr == A_CTRL) core_pinf <= wr_data[0];
        end
    end

    // Result capture only on a core answer inside WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_res   <= '0;
            y_res   <= '0;
            inf_res <= 1'b0;
        end else if (wait_done) begin
            x_res   <= core_x;
            y_res   <= core_y;
            inf_res <= core_inf;
        end
    end

    // Sticky flags and interrupt: clr first, then the events of this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err         <= 1'b0;
            timeout     <= 1'b0;
            done_sticky <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (clr_wr) begin
                err     <= 1'b0;
                timeout <= 1'b0;
                irq     <= 1'b0;
            end
            if (busy && (op_wr || start_wr)) err <= 1'b1;
            if (!busy && start_wr)           done_sticky <= 1'b0;
            if (wait_tmo)                    timeout <= 1'b1;
            if (wait_done || wait_tmo) begin
                irq         <= 1'b1;
                done_sticky <= 1'b1;
            end
        end
    end

    // Cycle counter: cleared at launch, counts every WAIT cycle, saturates.
    always_ff @(posedge clk) begin
        if (rst)                       cnt <= '0;
        else if (state_q == S_LAUNCH)  cnt <= '0;
        else if (state_q == S_WAIT)    cnt <= cnt_inc;
    end

    // Read address decode; unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < W; i++) begin
            if (addr == ADDR_W'(i))     rd_mux = x_res[i*BUS_W +: BUS_W];
            if (addr == ADDR_W'(W + i)) rd_mux = y_res[i*BUS_W +: BUS_W];
        end
        if (addr == A_INF)  rd_mux = BUS_W'(inf_res);
        if (addr == A_STAT) rd_mux = BUS_W'({timeout, err, done_sticky, busy});
        if (addr == A_CNT)  rd_mux = BUS_W'(cnt);
    end

    // Registered read port; a same-cycle write is seen by the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_data  <= rd_en ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_ecc_scalar_mul_bus_frontend.sv
// Bench for ecc_scalar_mul_bus_frontend: two instances (32-bit bus with timeout, 64-bit bus without).
// Directed steps plus randomized operations, checked against a register-level expectation model.
// The core is modelled inline by pulsing core_done after a chosen number of WAIT cycles.
module tb_ecc_scalar_mul_bus_frontend;

    localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam int TMO0 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, wr_en, rd_en, sel, core_done, core_inf;
    logic [4:0]   addr;
    logic [63:0]  wr_data;
    logic [255:0] core_x, core_y;
    logic         wr0, wr1, rd0, rd1;
    logic [31:0]  rd_data0;
    logic [63:0]  rd_data1;
    logic         rd_valid0, rd_valid1, done0, done1, irq0, irq1, cs0, cs1, pinf0, pinf1;
    logic [255:0] k0, px0, py0, k1, px1, py1;

    assign wr0 = wr_en & ~sel;
    assign wr1 = wr_en & sel;
    assign rd0 = rd_en & ~sel;
    assign rd1 = rd_en & sel;

    ecc_scalar_mul_bus_frontend #(.BUS_W(32), .OP_W(256), .ADDR_W(5), .CNT_W(32), .TIMEOUT_CYC(TMO0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .addr(addr), .wr_data(wr_data[31:0]),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .done(done0), .irq(irq0), .core_start(cs0),
        .core_k(k0), .core_px(px0), .core_py(py0), .core_pinf(pinf0),
        .core_done(core_done), .core_x(core_x), .core_y(core_y), .core_inf(core_inf));

    ecc_scalar_mul_bus_frontend #(.BUS_W(64), .OP_W(256), .ADDR_W(5), .CNT_W(32), .TIMEOUT_CYC(0)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .done(done1), .irq(irq1), .core_start(cs1),
        .core_k(k1), .core_px(px1), .core_py(py1), .core_pinf(pinf1),
        .core_done(core_done), .core_x(core_x), .core_y(core_y), .core_inf(core_inf));

    int n_vec = 0;
    int n_err = 0;
    int starts = 0;
    int dones = 0;

    // Pulse monitor on the selected instance, sampled away from the active edge.
    always @(negedge clk) begin
        if (sel ? cs1 : cs0)     starts++;
        if (sel ? done1 : done0) dones++;
    end

    // Expectation model of the selected instance's architectural registers.
    logic [255:0] exp_x, exp_y, exp_k, exp_px, exp_py;
    logic         exp_inf, exp_err, exp_tmo, exp_ds;
    int           exp_cnt;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nw();
        return sel ? 4 : 8;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] exp_status();
        return 256'({exp_tmo, exp_err, exp_ds, 1'b0});
    endfunction

    task automatic model_reset();
        exp_x = '0; exp_y = '0; exp_k = '0; exp_px = '0; exp_py = '0;
        exp_inf = 1'b0; exp_err = 1'b0; exp_tmo = 1'b0; exp_ds = 1'b0; exp_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int a, input logic [63:0] d);
        wr_en = 1'b1; addr = 5'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [63:0] d);
        rd_en = 1'b1; addr = 5'(a);
        tick();
        rd_en = 1'b0;
        check("rd_valid", 256'(sel ? rd_valid1 : rd_valid0), 256'(1));
        d = sel ? rd_data1 : 64'(rd_data0);
    endtask

    task automatic write_coord(input int base, input logic [255:0] v);
        int bw = 256 / nw();
        for (int i = 0; i < nw(); i++) bus_write(base + i, 64'(v >> (i * bw)));
    endtask

    task automatic read_coord(input int base, output logic [255:0] v);
        int bw = 256 / nw();
        logic [63:0] d;
        v = '0;
        for (int i = 0; i < nw(); i++) begin
            bus_read(base + i, d);
            v = v | (256'(d) << (i * bw));
        end
    endtask

    // Read back every result register and compare with the model.
    task automatic check_results();
        logic [255:0] v;
        logic [63:0]  d;
        read_coord(0, v);          check("x_result", v, exp_x);
        read_coord(nw(), v);       check("y_result", v, exp_y);
        bus_read(2 * nw(), d);     check("inf_result", 256'(d), 256'(exp_inf));
        bus_read(2 * nw() + 1, d); check("status", 256'(d), exp_status());
        bus_read(2 * nw() + 2, d); check("cycle_count", 256'(d), 256'(exp_cnt));
    endtask

    // Load operands and issue start; returns in the LAUNCH cycle.
    task automatic start_op(input logic [255:0] k, px, py, input logic pinf);
        write_coord(0, k);
        write_coord(nw(), px);
        write_coord(2 * nw(), py);
        bus_write(3 * nw(), 64'(pinf));
        bus_write(3 * nw() + 1, 64'd1);
        exp_k = k; exp_px = px; exp_py = py; exp_ds = 1'b0;
        check("core_start_launch", 256'(sel ? cs1 : cs0), 256'(1));
        check("core_k", sel ? k1 : k0, exp_k);
        check("core_px", sel ? px1 : px0, exp_px);
        check("core_py", sel ? py1 : py0, exp_py);
        check("core_pinf", 256'(sel ? pinf1 : pinf0), 256'(pinf));
    endtask

    // Core answers after j further WAIT cycles; returns in the FIN cycle.
    task automatic core_answer(input int j, input logic [255:0] x, y, input logic inf);
        repeat (j) tick();
        check("done_before_answer", 256'(sel ? done1 : done0), 256'(0));
        core_x = x; core_y = y; core_inf = inf; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        exp_x = x; exp_y = y; exp_inf = inf; exp_ds = 1'b1;
    endtask

    // Full successful operation with core latency of j+1 WAIT cycles.
    task automatic run_op(input logic [255:0] k, px, py, input logic pinf,
                          input int j, input logic [255:0] x, y, input logic inf);
        int s0 = starts;
        int d0 = dones;
        start_op(k, px, py, pinf);
        tick();
        check("core_start_once", 256'(sel ? cs1 : cs0), 256'(0));
        core_answer(j, x, y, inf);
        exp_cnt = j + 1;
        check("done_pulse", 256'(sel ? done1 : done0), 256'(1));
        check("irq_set", 256'(sel ? irq1 : irq0), 256'(1));
        tick();
        check("done_drop", 256'(sel ? done1 : done0), 256'(0));
        check("start_pulses", 256'(starts - s0), 256'(1));
        check("done_pulses", 256'(dones - d0), 256'(1));
        check_results();
    endtask

    initial begin
        logic [255:0] v;
        logic [63:0]  d;
        int           n, s0, d0;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; sel = 1'b0; addr = '0; wr_data = '0;
        core_done = 1'b0; core_inf = 1'b0; core_x = '0; core_y = '0;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;

        // Reset defaults.
        check("reset_irq", 256'(irq0), 256'(0));
        check("reset_core_start", 256'(cs0), 256'(0));
        check("reset_done", 256'(done0), 256'(0));
        check("reset_rd_valid", 256'(rd_valid0), 256'(0));
        check_results();

        // A stray core_done while idle must not touch results.
        core_x = rand256(); core_y = rand256(); core_inf = 1'b1; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check_results();

        // Unmapped read address returns zero with rd_valid.
        bus_read(30, d);
        check("unmapped_read", 256'(d), 256'(0));

        // Simultaneous read and write: both happen, the read sees the old value.
        wr_en = 1'b1; rd_en = 1'b1; addr = 5'd0; wr_data = 64'h1234_5678;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rw_read_old", 256'(rd_data0), 256'(exp_x[31:0]));
        check("rw_write_done", 256'(k0[31:0]), 256'(32'h1234_5678));

        // Nominal k=1 G operation, core answers at the 10th WAIT cycle.
        run_op(256'd1, GX, GY, 1'b0, 9, GX, GY, 1'b0);

        // Infinity result.
        run_op(rand256(), rand256(), rand256(), 1'b0, 4, '0, '0, 1'b1);

        // Busy protection: operand and start writes inside WAIT are dropped and set err.
        s0 = starts;
        start_op(rand256(), rand256(), rand256(), 1'b1);
        tick();
        bus_write(0, 64'hFFFF_FFFF);
        bus_write(3 * nw() + 1, 64'd1);
        check("busy_core_k_held", k0, exp_k);
        check("busy_no_relaunch", 256'(cs0), 256'(0));
        exp_err = 1'b1;
        core_answer(0, rand256(), rand256(), 1'b0);
        exp_cnt = 3;
        tick();
        check("busy_start_pulses", 256'(starts - s0), 256'(1));
        check_results();
        bus_write(3 * nw() + 1, 64'd2);
        exp_err = 1'b0;
        check("clr_irq", 256'(irq0), 256'(0));
        check_results();

        // Randomized operations.
        for (int r = 0; r < 4; r++) begin
            run_op(rand256(), rand256(), rand256(), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 14)), rand256(), rand256(), 1'($urandom_range(0, 1)));
        end

        // Timeout: core never answers; done after TMO0 WAIT cycles, results untouched.
        bus_write(3 * nw() + 1, 64'd2);
        d0 = dones;
        start_op(rand256(), rand256(), rand256(), 1'b0);
        tick();
        n = 0;
        while (!done0 && n < 100) begin
            tick();
            n++;
        end
        check("timeout_latency", 256'(n), 256'(TMO0));
        check("timeout_irq", 256'(irq0), 256'(1));
        tick();
        check("timeout_done_pulses", 256'(dones - d0), 256'(1));
        exp_tmo = 1'b1; exp_ds = 1'b1; exp_cnt = TMO0;
        check_results();

        // 64-bit bus instance: k=2 G operation over four words per coordinate.
        sel = 1'b1;
        model_reset();
        check_results();
        run_op(256'd2, GX, GY, 1'b0, 6, G2X, G2Y, 1'b0);

        // Reset in the middle of WAIT aborts with no done pulse.
        d0 = dones;
        start_op(rand256(), rand256(), rand256(), 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("abort_core_start", 256'(cs1), 256'(0));
        check("abort_irq", 256'(irq1), 256'(0));
        repeat (20) tick();
        check("abort_no_done", 256'(dones - d0), 256'(0));
        check_results();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ecc_scalar_mul_bus_frontend.md
Name: ecc_scalar_mul_bus_frontend

Overview:
Parametrised register-bus frontend for the ECC scalar-multiplier core. It generalises the fixed 32-bit/256-bit serial wrapper: bus word width, operand width and timeout are parameters, and it adds a status register, sticky error and timeout flags, an interrupt, and a last-operation cycle counter. It sits between the host serial bus and the scalar_mul core. It holds operands, launches the core with a start/done handshake, and captures results for read-back.

Parameters:
BUS_W, 32, bus data width in bits
OP_W, 256, operand/coordinate width in bits; must be a multiple of BUS_W; W = OP_W/BUS_W
ADDR_W, 5, bus address width; must satisfy 2^ADDR_W >= 3W+2
CNT_W, 32, width of the cycle counter
TIMEOUT_CYC, 0, maximum number of cycles in WAIT before abort; 0 disables the timeout

Ports:
clk  in  1  clock; all logic is on its rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  bus write strobe
rd_en  in  1  bus read strobe
addr  in  ADDR_W  bus word address
wr_data  in  BUS_W  write data
rd_data  out  BUS_W  read data, registered
rd_valid  out  1  asserted for 1 cycle, the cycle after rd_en
done  out  1  1-cycle pulse at operation end (success or timeout)
irq  out  1  level interrupt; cleared by the cmd clr bit
core_start  out  1  1-cycle start pulse to the core
core_k, core_px, core_py  out  OP_W  operand registers, held stable while busy
core_pinf  out  1  input point-at-infinity flag
core_done  in  1  core completion pulse
core_x, core_y  in  OP_W  core result coordinates
core_inf  in  1  core result infinity flag

Behaviour:
- Reset: all registers, rd_data, rd_valid, done, irq, core_start, status flags and counter go to 0. State goes to IDLE. Reset asserted mid-operation aborts the operation, with no done pulse and no result capture.
- Write map (word 0 = least-significant BUS_W bits):
  - 0..W-1: k
  - W..2W-1: Px
  - 2W..3W-1: Py
  - 3W: ctrl, bit0 = Pinf
  - 3W+1: cmd. bit0 = start; bit1 = clr, which clears irq, err and timeout. Both bits act as one-shots.
  - Other addresses are ignored.
- Read map (1-cycle latency; rd_valid = rd_en delayed by 1):
  - 0..W-1: X result
  - W..2W-1: Y result
  - 2W: bit0 = inf result
  - 2W+1: status = {.., timeout, err, done_sticky, busy} at bits 3..0
  - 2W+2: cycle count of the last operation
  - Other addresses read 0 with rd_valid still 1.
- Read/write same cycle: both are performed. The read returns the pre-write value.
- FSM:
  - IDLE: a start write moves to LAUNCH on the next edge.
  - LAUNCH: core_start=1 for exactly 1 cycle, counter cleared, then WAIT.
  - WAIT: the counter increments each cycle.
    - On core_done: latch core_x, core_y and core_inf, then go to FIN.
    - If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC: set timeout, leave results unchanged, go to FIN.
  - FIN: done=1 for 1 cycle, irq=1, done_sticky=1, then IDLE.
- busy = (state != IDLE). done_sticky is cleared by the next start.
- While busy, writes to operand, ctrl or start are ignored and set err. A clr write is honoured even while busy.
- start and clr in the same write: clr is applied first, then start.
- core_done in IDLE, LAUNCH or FIN is ignored.
- Counter saturates at 2^CNT_W-1.
- Latency: start write sampled at edge T → core_start high in cycle T+1. core_done sampled at edge D → done high in cycle D+1 and results readable from D+1.

Test Plan:
- Reset/defaults: assert rst 2 cycles → status reads 0x0, X words read 0, irq=0, core_start=0.
- Nominal op: write k=1, Px=Gx, Py=Gy (secp256k1), Pinf=0, start; core model returns (Gx,Gy,0) after 10 cycles → core_start pulses exactly once, done pulses once, irq=1, X/Y words read Gx/Gy, status=0x2, count reads 10±1 per the defined latency.
- Busy protection: during WAIT, write k word 0 = 0xFFFFFFFF and start → core_k unchanged, no second core_start, status err=1. Then clr → err=0, irq=0.
- Timeout: TIMEOUT_CYC=16, core never answers → done pulses 16 cycles after WAIT entry, status timeout=1, results hold previous values.
- Infinity: core returns inf=1, X=Y=0 → address 2W reads 0x1, Y words read 0.
- Parametrisation: BUS_W=64, OP_W=256 (W=4) → same k=2 op with result (G2x,G2y) reads back correctly over 4 words per coordinate; reset mid-WAIT → state IDLE, no done pulse.
